// File: rtl/mcu_bram_stream_reader.sv
// mcu_bram_stream_reader
// Reads a contiguous block of BRAM words and streams them on an AXI-Stream
// master. A read is only issued when the words already in flight plus the
// words parked in the output FIFO leave room for it, so a returning word
// always finds a free FIFO slot.

module mcu_bram_stream_reader #(
  parameter int BRAM_VALID_SIG = 1,
  parameter int READ_LATENCY   = 1,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  fsm_clk,
  input  logic                  rst_n,
  input  logic                  op_start,
  input  logic [ADDR_WIDTH-1:0] op_base_addr,
  input  logic [ADDR_WIDTH:0]   op_size,
  output logic                  op_busy,
  output logic                  op_done,
  output logic                  op_error,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_rddata,
  input  logic                  bram_rdack,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
  // One past the highest addressable word, held wide enough to never wrap.
  localparam logic [ADDR_WIDTH+1:0] ADDR_SPAN = {2'b01, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t state_r, state_nxt_s;

  logic [ADDR_WIDTH-1:0]   base_r;
  logic [ADDR_WIDTH:0]     size_r;
  logic [ADDR_WIDTH:0]     issued_r;
  logic [ADDR_WIDTH:0]     sent_r;
  logic [ADDR_WIDTH:0]     last_idx_s;
  logic [CNT_W-1:0]        inflight_r;
  logic [CNT_W-1:0]        fifo_count_r;
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic [READ_LATENCY-1:0] ret_sr_r;
  logic                    op_error_r;

  logic                    ret_raw_s;
  logic                    ret_valid_s;
  logic                    spurious_s;
  logic                    credit_ok_s;
  logic                    issue_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    tvalid_s;
  logic                    last_hs_s;
  logic                    flush_s;
  logic                    start_bad_s;
  logic [ADDR_WIDTH+1:0]   end_addr_s;

  // Datapath qualifiers shared by the FSM, counters and FIFO.
  always_comb begin
    end_addr_s  = {2'b00, op_base_addr} + {1'b0, op_size};
    start_bad_s = (op_size == '0) || (end_addr_s > ADDR_SPAN);
    last_idx_s  = size_r - (ADDR_WIDTH+1)'(1);
    ret_raw_s   = (BRAM_VALID_SIG != 0) ? bram_rdack : ret_sr_r[READ_LATENCY-1];
    ret_valid_s = ret_raw_s && (inflight_r != '0);
    spurious_s  = (BRAM_VALID_SIG != 0) && bram_rdack && (inflight_r == '0) &&
                  (state_r != S_IDLE) && (state_r != S_ERR);
    credit_ok_s = ({1'b0, inflight_r} + {1'b0, fifo_count_r}) < DEPTH_C;
    issue_s     = (state_r == S_ISSUE) && (issued_r < size_r) && credit_ok_s;
    push_s      = ret_valid_s && ((state_r == S_ISSUE) || (state_r == S_DRAIN));
    tvalid_s    = (fifo_count_r != '0);
    pop_s       = tvalid_s && m_axis_tready;
    last_hs_s   = pop_s && (sent_r == last_idx_s);
    flush_s     = (state_nxt_s == S_ERR);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (op_start) begin
          if (start_bad_s) begin
            state_nxt_s = S_ERR;
          end else begin
            state_nxt_s = S_ISSUE;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (spurious_s) begin
          state_nxt_s = S_ERR;
        end else if (issue_s && (issued_r == last_idx_s)) begin
          state_nxt_s = S_DRAIN;
        end else begin
          state_nxt_s = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (spurious_s) begin
          state_nxt_s = S_ERR;
        end else if (last_hs_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      S_DONE: begin
        if (spurious_s) begin
          state_nxt_s = S_ERR;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ERR: begin
        // Stay until every outstanding read has come back and been dropped.
        if (inflight_r == '0) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_ERR;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register and the one-cycle error pulse raised on entry to ERR.
  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      op_error_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      op_error_r <= (state_nxt_s == S_ERR) && (state_r != S_ERR);
    end
  end

  // Transfer descriptor and issue/send progress counters.
  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r   <= '0;
      size_r   <= '0;
      issued_r <= '0;
      sent_r   <= '0;
    end else if ((state_r == S_IDLE) && op_start && !start_bad_s) begin
      base_r   <= op_base_addr;
      size_r   <= op_size;
      issued_r <= '0;
      sent_r   <= '0;
    end else begin
      if (issue_s) begin
        issued_r <= issued_r + (ADDR_WIDTH+1)'(1);
      end
      if (pop_s && !flush_s) begin
        sent_r <= sent_r + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  // Outstanding-read counter and fixed-latency return tracker.
  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= '0;
      ret_sr_r   <= '0;
    end else begin
      ret_sr_r <= (ret_sr_r << 1) | READ_LATENCY'(issue_s);
      case ({issue_s, ret_valid_s})
        2'b10:   inflight_r <= inflight_r + CNT_W'(1);
        2'b01:   inflight_r <= inflight_r - CNT_W'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // FIFO pointers and occupancy; an error flushes everything queued.
  always_ff @(posedge fsm_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      fifo_count_r <= '0;
    end else if (flush_s) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      fifo_count_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1);
        2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // FIFO storage; contents are only visible while the FIFO is non-empty.
  always_ff @(posedge fsm_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bram_rddata;
    end
  end

  // Output drive, all derived from registered state.
  always_comb begin
    op_busy       = (state_r != S_IDLE);
    op_done       = (state_r == S_DONE);
    op_error      = op_error_r;
    bram_en       = issue_s;
    bram_addr     = issue_s ? (base_r + issued_r[ADDR_WIDTH-1:0]) : '0;
    m_axis_tvalid = tvalid_s;
    m_axis_tdata  = tvalid_s ? mem_r[rd_ptr_r] : '0;
    m_axis_tlast  = tvalid_s && (sent_r == last_idx_s);
  end

endmodule

// File: tb/tb_mcu_bram_stream_reader.sv
// Testbench for mcu_bram_stream_reader: one instance with fixed read latency,
// one with rdack-qualified returns. BRAM models return the word address as data.

module tb_mcu_bram_stream_reader;

  localparam int DW    = 16;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]    start;
  logic [1:0]    tready;
  logic [AW-1:0] base_in;
  logic [AW:0]   size_in;
  logic          spur;

  wire [1:0]     busy, done, err, en, tvalid, tlast;
  wire [DW-1:0]  tdata0, tdata1;
  wire [AW-1:0]  addr0, addr1;
  logic [DW-1:0] rddata0, rddata1;
  logic          ack1_r;
  wire [1:0]     rdack = {ack1_r | spur, 1'b0};

  int tests = 0;
  int fails = 0;

  mcu_bram_stream_reader #(.BRAM_VALID_SIG(0), .READ_LATENCY(1), .DATA_WIDTH(DW),
                           .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) u_dut0 (
    .fsm_clk(clk), .rst_n(rst_n), .op_start(start[0]), .op_base_addr(base_in),
    .op_size(size_in), .op_busy(busy[0]), .op_done(done[0]), .op_error(err[0]),
    .bram_en(en[0]), .bram_addr(addr0), .bram_rddata(rddata0), .bram_rdack(rdack[0]),
    .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid[0]), .m_axis_tready(tready[0]),
    .m_axis_tlast(tlast[0]));

  mcu_bram_stream_reader #(.BRAM_VALID_SIG(1), .READ_LATENCY(1), .DATA_WIDTH(DW),
                           .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) u_dut1 (
    .fsm_clk(clk), .rst_n(rst_n), .op_start(start[1]), .op_base_addr(base_in),
    .op_size(size_in), .op_busy(busy[1]), .op_done(done[1]), .op_error(err[1]),
    .bram_en(en[1]), .bram_addr(addr1), .bram_rddata(rddata1), .bram_rdack(rdack[1]),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid[1]), .m_axis_tready(tready[1]),
    .m_axis_tlast(tlast[1]));

  // Fixed one-cycle-latency BRAM: data is the low bits of the address.
  always @(posedge clk) begin
    if (en[0]) rddata0 <= addr0[DW-1:0];
  end

  // In-order BRAM with a random 1..5 cycle delay per read, qualified by rdack.
  int            cyc_r;
  int            last_due;
  logic [2:0]    dly_r;
  logic          sched_v [64];
  logic [DW-1:0] sched_d [64];
  int            due_w;
  assign due_w = ((cyc_r + int'(dly_r)) > last_due) ? (cyc_r + int'(dly_r)) : (last_due + 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_r    <= 0;
      last_due <= 0;
      dly_r    <= 3'd1;
      ack1_r   <= 1'b0;
      rddata1  <= '0;
      for (int i = 0; i < 64; i++) sched_v[i] <= 1'b0;
    end else begin
      cyc_r <= cyc_r + 1;
      dly_r <= 3'($urandom_range(5, 1));
      sched_v[(cyc_r + 1) % 64] <= 1'b0;
      if (en[1]) begin
        last_due <= due_w;
        if (due_w != cyc_r + 1) begin
          sched_v[due_w % 64] <= 1'b1;
          sched_d[due_w % 64] <= addr1[DW-1:0];
        end
      end
      if (en[1] && (due_w == cyc_r + 1)) begin
        ack1_r  <= 1'b1;
        rddata1 <= addr1[DW-1:0];
      end else begin
        ack1_r  <= sched_v[(cyc_r + 1) % 64];
        rddata1 <= sched_d[(cyc_r + 1) % 64];
      end
    end
  end

  typedef struct {
    logic          tvalid, tlast, en, busy, done, err;
    logic [DW-1:0] tdata;
    logic [AW-1:0] addr;
  } obs_t;

  function automatic obs_t get_obs(input int d);
    obs_t o;
    o.tvalid = tvalid[d];
    o.tlast  = tlast[d];
    o.en     = en[d];
    o.busy   = busy[d];
    o.done   = done[d];
    o.err    = err[d];
    o.tdata  = (d == 0) ? tdata0 : tdata1;
    o.addr   = (d == 0) ? addr0 : addr1;
    return o;
  endfunction

  function automatic logic [63:0] all_outs(input int d);
    obs_t o = get_obs(d);
    return {10'd0, o.busy, o.done, o.err, o.en, o.tvalid, o.tlast, o.tdata, o.addr};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer and checks it against the expected word sequence.
  task automatic run_xfer(input int d, input logic [AW-1:0] b, input int n, input int pct,
                          input int stall, input bit repulse,
                          output int first_v, output int gaps, output int stall_en);
    obs_t o;
    int got, n_en, n_done, n_err, done_cyc, last_hs, prev_hs, max_out;
    bit r;
    logic [DW-1:0] exp_d;
    got = 0; n_en = 0; n_done = 0; n_err = 0; done_cyc = -1; last_hs = -1;
    prev_hs = -1; max_out = 0; first_v = -1; gaps = 0; stall_en = 0;
    @(negedge clk);
    base_in  = b;
    size_in  = (AW+1)'(n);
    start[d] = 1'b1;
    tready[d] = 1'b0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      start[d] = repulse && (cyc == 2);
      if (repulse && (cyc == 2)) size_in = (AW+1)'(3);
      o = get_obs(d);
      if (n_done > 0) begin
        check("busy_after_done", o.busy, 0);
        break;
      end
      if (o.en) n_en++;
      if (o.en && cyc <= stall) stall_en++;
      if (o.err) n_err++;
      if (o.done) begin n_done++; done_cyc = cyc; end
      if (o.tvalid && first_v < 0) first_v = cyc;
      if (n_en - got > max_out) max_out = n_en - got;
      r = (cyc > stall) && ($urandom_range(99, 0) < pct);
      tready[d] = r;
      if (o.tvalid && r) begin
        exp_d = DW'(b + AW'(got));
        check("tdata", o.tdata, exp_d);
        check("tlast", o.tlast, (got == n - 1));
        if (got > 0 && cyc != prev_hs + 1) gaps++;
        prev_hs = cyc;
        if (got == n - 1) last_hs = cyc;
        got++;
      end
    end
    start[d]  = 1'b0;
    tready[d] = 1'b0;
    check("word_count", got, n);
    check("done_count", n_done, 1);
    check("done_timing", done_cyc, last_hs + 1);
    check("read_count", n_en, n);
    check("no_error", n_err, 0);
    check("credit_bound", (max_out <= DEPTH), 1);
  endtask

  // A start that must be rejected: one error pulse, no reads.
  task automatic err_start(input int d, input logic [AW-1:0] b, input logic [AW:0] n);
    obs_t o;
    @(negedge clk);
    base_in = b; size_in = n; start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    o = get_obs(d);
    check("err_pulse", {o.err, o.busy, o.en}, 3'b110);
    @(negedge clk);
    o = get_obs(d);
    check("err_end", {o.err, o.busy, o.en}, 3'b000);
  endtask

  initial begin
    int fv, gp, se, hs, nd;
    obs_t o;
    rst_n = 1'b0; start = '0; tready = '0; base_in = '0; size_in = '0; spur = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs_d0", all_outs(0), 64'd0);
    check("reset_outs_d1", all_outs(1), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic transfer: latency and one word per cycle.
    run_xfer(0, 32'h10, 5, 100, 0, 0, fv, gp, se);
    check("first_valid_latency", fv, 3);
    check("throughput_gaps", gp, 0);

    // Backpressure: reads stop once the credit window is used up.
    run_xfer(0, 32'h200, 8, 100, 10, 0, fv, gp, se);
    check("stall_reads", se, DEPTH);

    // rdack mode with random return delays.
    run_xfer(1, 32'h1000, 16, 100, 0, 0, fv, gp, se);
    run_xfer(1, 32'h2000, 16, 50, 0, 0, fv, gp, se);

    // Highest legal block, ending exactly at the top of the address space.
    run_xfer(0, 32'hFFFF_FFFE, 2, 100, 0, 0, fv, gp, se);
    run_xfer(1, 32'hFFFF_FFFF, 1, 100, 0, 0, fv, gp, se);

    // Random transfers on both variants.
    for (int i = 0; i < 6; i++) begin
      run_xfer(i % 2, $urandom & 32'h00FF_FFFF, $urandom_range(20, 1),
               $urandom_range(100, 30), 0, 0, fv, gp, se);
    end

    // Rejected starts.
    err_start(0, 32'h0, '0);
    err_start(1, 32'h0, '0);
    err_start(0, 32'hFFFF_FFFE, (AW+1)'(3));
    err_start(1, 32'hFFFF_FFFE, (AW+1)'(3));

    // Spurious rdack while idle is ignored.
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    o = get_obs(1);
    check("spur_idle", {o.err, o.busy}, 2'b00);
    @(negedge clk);
    o = get_obs(1);
    check("spur_idle_after", {o.err, o.busy}, 2'b00);

    // Spurious rdack while busy with nothing outstanding.
    @(negedge clk);
    base_in = 32'h300; size_in = (AW+1)'(8); start[1] = 1'b1; tready[1] = 1'b0;
    @(negedge clk); start[1] = 1'b0;
    repeat (30) @(negedge clk);
    o = get_obs(1);
    check("spur_fifo_held", {o.tvalid, o.busy}, 2'b11);
    spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    o = get_obs(1);
    check("spur_busy_err", {o.err, o.busy, o.tvalid}, 3'b110);
    @(negedge clk);
    o = get_obs(1);
    check("spur_busy_idle", {o.err, o.busy, o.tvalid}, 3'b000);
    run_xfer(1, 32'h400, 6, 100, 0, 0, fv, gp, se);

    // Reset in the middle of a transfer.
    @(negedge clk);
    base_in = 32'h40; size_in = (AW+1)'(10); start[0] = 1'b1; tready[0] = 1'b1;
    hs = 0;
    for (int c = 0; c < 50 && hs < 4; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (tvalid[0] && tready[0]) hs++;
    end
    check("mid_reset_words", hs, 4);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_outs", all_outs(0), 64'd0);
    tready[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done[0] || err[0] || busy[0]) nd++;
    end
    check("post_reset_quiet", nd, 0);
    run_xfer(0, 32'h50, 2, 100, 0, 0, fv, gp, se);

    // Start re-pulsed during ISSUE is ignored.
    run_xfer(0, 32'h80, 6, 100, 0, 1, fv, gp, se);
    run_xfer(1, 32'h90, 6, 100, 0, 1, fv, gp, se);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
